// File: rtl/reset_ctrl_pkg.sv
// Shared types and constants for the reset sequencer: cause codes, FSM states
// and a counter-width helper.
package reset_ctrl_pkg;

  localparam int CAUSE_W = 2;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_SW  = 2'd1,
    CAUSE_EXT = 2'd2
  } cause_e;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    STAGE = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser plus saturating low-time counter for an active-low
// asynchronous button; pressed drops as soon as the synchronised input is high.
module debounce_sync
  import reset_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_n,
  output logic pressed
);

  localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;

  // NOTE: non-blocking assignments for all flop state so update order never matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= in_n;
      r_sync2 <= r_sync1;
      if (r_sync2)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign pressed = ~r_sync2 && (r_cnt == CNT_MAX);

endmodule

// File: rtl/reset_ctrl.sv
// Reset sequencer: stretches any request (POR, software pulse, debounced button)
// into a hold period, then releases the domain resets one by one.
module reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter int N_DOMAINS       = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_CYCLES    = 4,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_sw,
  input  logic                 req_ext_n,
  output logic [N_DOMAINS-1:0] rst_n_out,
  output logic                 busy,
  output logic [CAUSE_W-1:0]   cause
);

  localparam int CW = cnt_width((HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);

  state_e               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [N_DOMAINS-1:0] r_out, w_out_nxt;
  logic [N_DOMAINS:0]   w_out_shift;
  cause_e               r_cause, w_cause_nxt;
  logic                 r_busy;
  logic                 w_ext_pressed;
  logic                 w_req;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_n    (req_ext_n),
    .pressed (w_ext_pressed)
  );

  assign w_req = req_sw | w_ext_pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_out   <= '0;
      r_cause <= CAUSE_POR;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_cause <= w_cause_nxt;
      r_busy  <= ~&w_out_nxt;
    end
  end

  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_cause_nxt = r_cause;
    // Shifting a one in from the bottom releases the next domain in order.
    w_out_shift = {r_out, 1'b1};

    if (w_req) begin
      w_state_nxt = HOLD;
      w_cnt_nxt   = '0;
      w_out_nxt   = '0;
      w_cause_nxt = w_ext_pressed ? CAUSE_EXT : CAUSE_SW;
    end else begin
      case (r_state)
        HOLD: begin
          w_out_nxt = '0;
          if (r_cnt == HOLD_LAST) begin
            w_out_nxt   = w_out_shift[N_DOMAINS-1:0];
            w_cnt_nxt   = '0;
            w_state_nxt = (N_DOMAINS == 1) ? RUN : STAGE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        STAGE: begin
          if (r_cnt == STAGE_LAST) begin
            w_out_nxt = w_out_shift[N_DOMAINS-1:0];
            w_cnt_nxt = '0;
            if (&w_out_shift[N_DOMAINS-1:0])
              w_state_nxt = RUN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        RUN: begin
          w_out_nxt = '1;
          w_cnt_nxt = '0;
        end
        default: begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_out_nxt   = '0;
        end
      endcase
    end
  end

  assign rst_n_out = r_out;
  assign busy      = r_busy;
  assign cause     = r_cause;

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: edge-counting model of the release schedule checked every
// cycle, plus literal timing checks for POR, software, button and async reset.
`timescale 1ns/1ps
module tb_reset_ctrl;

  localparam int N     = 3;
  localparam int HOLD  = 16;
  localparam int STG   = 4;
  localparam int DEB   = 1024;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_sw;
  logic         req_ext_n;
  logic [N-1:0] rst_n_out;
  logic         busy;
  logic [1:0]   cause;

  int total = 0;
  int bad   = 0;

  reset_ctrl #(
    .N_DOMAINS(N), .HOLD_CYCLES(HOLD), .STAGE_CYCLES(STG), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_sw(req_sw), .req_ext_n(req_ext_n),
    .rst_n_out(rst_n_out), .busy(busy), .cause(cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs depend only on request-free edges since the last request/reset.
  int         m_since;
  bit         m_s1, m_s2;
  int         m_low;
  logic [1:0] m_cause;
  bit         m_pressed;

  assign m_pressed = !m_s2 && (m_low >= DEB - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_since <= 0;
      m_s1    <= 1'b1;
      m_s2    <= 1'b1;
      m_low   <= 0;
      m_cause <= 2'd0;
    end else begin
      if (req_sw || m_pressed) begin
        m_since <= 0;
        m_cause <= m_pressed ? 2'd2 : 2'd1;
      end else if (m_since < 1000000) begin
        m_since <= m_since + 1;
      end
      m_s1  <= req_ext_n;
      m_s2  <= m_s1;
      m_low <= m_s2 ? 0 : ((m_low < DEB - 1) ? m_low + 1 : m_low);
    end
  end

  function automatic logic [N-1:0] model_out(input int since);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (since >= HOLD + i * STG);
    return v;
  endfunction

  always @(negedge clk) begin
    check("model_out",   rst_n_out, model_out(m_since));
    check("model_busy",  busy,      (m_since < HOLD + (N - 1) * STG));
    check("model_cause", cause,     m_cause);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int found;
  int btn_left;

  initial begin
    rst_n = 1'b0; req_sw = 1'b0; req_ext_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out", rst_n_out, 0);
    check("reset_busy", busy, 1);
    check("reset_cause", cause, 0);

    // POR release: bits at edges 16, 20, 24.
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk) check("por_e15", rst_n_out, 3'b000);
    @(posedge clk);
    @(negedge clk) check("por_e16", rst_n_out, 3'b001);
    repeat (4) @(posedge clk);
    @(negedge clk) check("por_e20", rst_n_out, 3'b011);
    check("por_e20_busy", busy, 1);
    repeat (4) @(posedge clk);
    @(negedge clk) check("por_e24", rst_n_out, 3'b111);
    check("por_e24_busy", busy, 0);
    check("por_cause", cause, 0);

    // Software reset from RUN.
    repeat (5) @(negedge clk);
    req_sw = 1'b1;
    @(posedge clk);
    @(negedge clk) req_sw = 1'b0;
    check("sw_out", rst_n_out, 3'b000);
    check("sw_busy", busy, 1);
    check("sw_cause", cause, 1);
    repeat (15) @(posedge clk);
    @(negedge clk) check("sw_t15", rst_n_out, 3'b000);
    @(posedge clk);
    @(negedge clk) check("sw_t16", rst_n_out, 3'b001);
    repeat (8) @(posedge clk);
    @(negedge clk) check("sw_t24", rst_n_out, 3'b111);

    // Mid-sequence request one edge after bit 0 releases.
    req_sw = 1'b1;
    @(posedge clk);
    @(negedge clk) req_sw = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk) check("mid_bit0", rst_n_out, 3'b001);
    req_sw = 1'b1;
    @(posedge clk);
    @(negedge clk) req_sw = 1'b0;
    check("mid_reassert", rst_n_out, 3'b000);
    repeat (15) @(posedge clk);
    @(negedge clk) check("mid_s15", rst_n_out, 3'b000);
    @(posedge clk);
    @(negedge clk) check("mid_s16", rst_n_out, 3'b001);
    repeat (4) @(posedge clk);
    @(negedge clk) check("mid_s20", rst_n_out, 3'b011);
    repeat (4) @(posedge clk);
    @(negedge clk) check("mid_s24", rst_n_out, 3'b111);

    // Short button glitch is ignored.
    req_ext_n = 1'b0;
    repeat (500) @(negedge clk);
    req_ext_n = 1'b1;
    repeat (5) @(negedge clk);
    check("glitch_out", rst_n_out, 3'b111);
    check("glitch_cause", cause, 1);

    // Long press: reset asserts at edge 1026 after the falling edge.
    req_ext_n = 1'b0;
    found = -1;
    for (int k = 1; k <= 1200 && found < 0; k++) begin
      @(posedge clk); #1;
      if (busy) found = k;
    end
    check("ext_assert_edge", found, 1026);
    check("ext_cause", cause, 2);
    repeat (2000 - 1026) @(posedge clk);
    @(negedge clk) req_ext_n = 1'b1;
    found = -1;
    for (int k = 1; k <= 200 && found < 0; k++) begin
      @(posedge clk); #1;
      if (rst_n_out[0]) found = k;
    end
    check("ext_release_edge", found, 18);
    repeat (10) @(negedge clk);
    check("ext_run", rst_n_out, 3'b111);

    // Software pulse on the edge the debounced press is taken: EXT wins.
    req_ext_n = 1'b0;
    repeat (1025) @(posedge clk);
    @(negedge clk) req_sw = 1'b1;
    @(posedge clk);
    @(negedge clk) req_sw = 1'b0;
    check("both_out", rst_n_out, 3'b000);
    check("both_cause", cause, 2);
    repeat (20) @(negedge clk);
    req_ext_n = 1'b1;
    repeat (40) @(negedge clk);
    check("both_run", rst_n_out, 3'b111);

    // Random mix of software pulses and button presses of varied length.
    btn_left = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      req_sw = ($urandom_range(0, 149) == 0);
      if (btn_left > 0) begin
        btn_left--;
        if (btn_left == 0) req_ext_n = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        req_ext_n = 1'b0;
        btn_left  = $urandom_range(20, 1600);
      end
    end
    @(negedge clk);
    req_sw = 1'b0; req_ext_n = 1'b1;

    // Asynchronous POR while running.
    found = -1;
    for (int k = 0; k < 3000 && found < 0; k++) begin
      @(negedge clk);
      if (!busy) found = k;
    end
    check("reach_run", (found >= 0), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("apor_out", rst_n_out, 3'b000);
    check("apor_busy", busy, 1);
    check("apor_cause", cause, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk) check("apor_e16", rst_n_out, 3'b001);
    repeat (8) @(posedge clk);
    @(negedge clk) check("apor_e24", rst_n_out, 3'b111);
    check("apor_busy_end", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_ctrl.md
Name: reset_ctrl

Overview:
- Single-clock reset sequencer. Generates the chip's stretched, staged, active-low reset outputs from three sources: power-on reset, a software request pulse and an external button.
- It initiates resets; each consumer domain re-synchronises its rst_n_out bit locally. Outputs assert from this block and release synchronously here.
- It also reports the cause of the most recent reset.

Parameters:
- N_DOMAINS, 3, number of staged reset outputs (>= 1).
- HOLD_CYCLES, 16, clk cycles all outputs stay asserted after the last active request (>= 2).
- STAGE_CYCLES, 4, clk cycles between release of consecutive domains (>= 1).
- DEBOUNCE_CYCLES, 1024, consecutive synchronised-low cycles before a button press is accepted (>= 2).
- Counter widths are derived with $clog2 of the relevant parameter and are not user parameters.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, power-on reset. Asynchronous assert, active-low.
- req_sw, input, 1, synchronous software reset request. Single-cycle pulse, active-high.
- req_ext_n, input, 1, external button, asynchronous to clk, active-low.
- rst_n_out, output, N_DOMAINS, staged resets, active-low. Bit 0 releases first.
- busy, output, 1, high whenever any rst_n_out bit is low.
- cause, output, 2, cause of the last reset: 0 POR, 1 SW, 2 EXT. Code 3 is unused.

Behaviour:
- All outputs are registered; there are no combinational paths from inputs to outputs.
- While rst_n is low, asynchronously:
  - rst_n_out = all zeros, busy = 1, cause = 0;
  - FSM in HOLD with counters cleared;
  - button synchroniser = 1, debounce counter = 0.
- req_ext_n path:
  - 2-flop synchroniser, reset value 1.
  - Debounce counter increments while the synchronised input is low and clears when it is high.
  - ext_pressed is asserted when the count reaches DEBOUNCE_CYCLES-1 and stays asserted while low.
  - Release is immediate: ext_pressed clears on the first synchronised high.
  - The counter saturates and does not wrap.
- A request is (req_sw sampled high) OR ext_pressed.
- FSM states:
  - HOLD: all outputs low, hold counter runs. Any request clears the counter; a held button keeps it at 0. After HOLD_CYCLES request-free edges, set rst_n_out[0] = 1 and go to STAGE (or RUN if N_DOMAINS == 1).
  - STAGE: every STAGE_CYCLES edges release the next bit. Releasing bit N_DOMAINS-1 moves to RUN on the same edge.
  - RUN: all outputs high, busy = 0.
- A request in any state takes effect on the edge that samples it:
  - on that edge, rst_n_out goes to all zeros, busy goes to 1 and the FSM enters HOLD with counters cleared;
  - cause is updated on the same edge.
- Cause priority when sources coincide: EXT over SW. POR is set only by rst_n.
- Release timing, counting edges from the first clk edge after rst_n deasserts as edge 1, with no further requests:
  - rst_n_out[i] rises at edge HOLD_CYCLES + i*STAGE_CYCLES;
  - busy falls on the same edge as the last bit.
- rst_n_out bits are monotonic in index: bit i is never high while bit i-1 is low.
- req_sw during HOLD restarts the hold count; cause becomes SW.

Decomposition:
- Package reset_ctrl_pkg holds:
  - the cause width constant (2);
  - cause codes CAUSE_POR=0, CAUSE_SW=1, CAUSE_EXT=2;
  - FSM state encodings HOLD, STAGE, RUN.
- One sub-module, debounce_sync: 2-flop synchroniser plus saturating debounce counter.
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, rst_n, in_n, pressed.
  - Reusable for other button inputs.

Test Plan:
- POR release, defaults: drop rst_n, raise it, count edges -> rst_n_out bit 0 high at edge 16, bit 1 at 20, bit 2 at 24; busy falls at edge 24; cause=0 throughout.
- Software reset from RUN: req_sw high, sampled at edge T -> rst_n_out=3'b000 and busy=1 after edge T; bit 0 rises at T+16, bit 2 at T+24; cause=1 from edge T.
- Button bounce and press:
  - 500-cycle low glitch on req_ext_n -> no output change.
  - 2000-cycle low -> reset asserts about 1026 cycles after the falling edge (±1); cause=2.
  - Bit 0 rises 16 edges after ext_pressed clears, which is about 2 cycles after the button rises.
- Mid-sequence request: req_sw sampled one edge after bit 0 releases (STAGE) -> bit 0 re-asserts on that edge, and the full 16/20/24 sequence restarts from it.
- Simultaneous sources: req_sw sampled on the same edge ext_pressed asserts -> cause=2 (EXT wins), single reset sequence.
- Asynchronous POR mid-RUN: rst_n low between clk edges -> all outputs low immediately without a clk edge; cause=0; busy=1; normal release after rst_n rises.
